ff_d_write_arbiter: RTL

Round-robin write arbiter that shares one P-bit enabled register (the FF_D storage element) among four requesters. Each requester presents a P-bit word plus a request. The arbiter picks one winner, steers its word onto the register's D input, pulses the register's EN for exactly one cycle, and then acknowledges the winner. The block sits between the datapath sub-units that produce operands and the single shared operand/result register they write into.

---
 rtl/ff_d_write_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ff_d_write_arbiter.sv
// ff_d_write_arbiter
//   Round-robin write arbiter that shares one P-bit enabled register (FF_D)
//   between four requesters. A winner is chosen in IDLE, its word is steered
//   onto D_REG while EN_REG is high for one cycle (WRITE), and the winner is
//   acknowledged for one cycle (DONE) before the FSM returns to IDLE.
//
//   Optional feature macro: FF_D_ARB_PRIO0_EN
//     defined   : requester 0 has fixed top priority; requesters 1-3 share
//                 round-robin. The pointer still advances after every grant.
//     undefined : pure round-robin across all four requesters.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   REQ      in   [3:0]     per-requester write request
//   DATA_IN  in   [4*P-1:0] requester words, requester i at [i*P +: P]
//   GNT      out  [3:0]     one-hot grant, held through WRITE and DONE
//   ACK      out  [3:0]     one-hot one-cycle completion pulse (DONE)
//   EN_REG   out            enable to the shared register (WRITE only)
//   D_REG    out  [P-1:0]   data to the shared register, zero outside WRITE
//   BUSY     out            high while the FSM is outside IDLE
module ff_d_write_arbiter #(
  parameter int P = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     REQ,
  input  logic [4*P-1:0] DATA_IN,
  output logic [3:0]     GNT,
  output logic [3:0]     ACK,
  output logic           EN_REG,
  output logic [P-1:0]   D_REG,
  output logic           BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t       state_r, state_next_s;
  logic [1:0]   ptr_r, ptr_next_s;
  logic [1:0]   win_r, win_next_s;
  logic [3:0]   gnt_r, gnt_next_s;
  logic [3:0]   ack_r, ack_next_s;
  logic         en_r, en_next_s;
  logic [1:0]   pick_s;
  logic [P-1:0] d_reg_s;

  // One-hot encode a requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] base;
    base = 4'b0001;
    return base << idx;
  endfunction

  // First set request bit searching ptr, ptr+1, ... (mod 4). Iterating from
  // the farthest offset down lets the nearest requester overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    res = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection from the current requests and pointer (only used in IDLE).
  always_comb begin
    pick_s = 2'd0;
`ifdef FF_D_ARB_PRIO0_EN
    if (REQ[0]) begin
      pick_s = 2'd0;
    end else begin
      pick_s = rr_pick(REQ & 4'b1110, ptr_r);
    end
`else
    pick_s = rr_pick(REQ, ptr_r);
`endif
  end

  // Next-state and next-output logic; outputs are registered one edge later.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    win_next_s   = win_r;
    gnt_next_s   = gnt_r;
    ack_next_s   = 4'b0000;
    en_next_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (REQ != 4'b0000) begin
          state_next_s = ST_WRITE;
          win_next_s   = pick_s;
          gnt_next_s   = onehot4(pick_s);
          en_next_s    = 1'b1;
        end else begin
          gnt_next_s   = 4'b0000;
        end
      end
      ST_WRITE: begin
        // REQ is not looked at here: a dropped request still completes.
        state_next_s = ST_DONE;
        ack_next_s   = gnt_r;
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        gnt_next_s   = 4'b0000;
        ptr_next_s   = win_r + 2'd1;
      end
      default: begin
        state_next_s = ST_IDLE;
        gnt_next_s   = 4'b0000;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd0;
      win_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      ack_r   <= 4'b0000;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      win_r   <= win_next_s;
      gnt_r   <= gnt_next_s;
      ack_r   <= ack_next_s;
      en_r    <= en_next_s;
    end
  end

  // Steer the granted word onto D only while writing; zero otherwise so
  // nothing stray is presented to the register.
  always_comb begin
    d_reg_s = '0;
    if (state_r == ST_WRITE) begin
      case (win_r)
        2'd0:    d_reg_s = DATA_IN[0*P +: P];
        2'd1:    d_reg_s = DATA_IN[1*P +: P];
        2'd2:    d_reg_s = DATA_IN[2*P +: P];
        2'd3:    d_reg_s = DATA_IN[3*P +: P];
        default: d_reg_s = '0;
      endcase
    end else begin
      d_reg_s = '0;
    end
  end

  assign GNT    = gnt_r;
  assign ACK    = ack_r;
  assign EN_REG = en_r;
  assign D_REG  = d_reg_s;
  assign BUSY   = (state_r != ST_IDLE);

endmodule
